// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified instruction/data memory arbiter.
// The response tag records which port owns the read data arriving next cycle.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_MAX_WAIT   = 4;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_LS   = 2'd2
  } rsp_tag_e;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the IF port, LS port and shared memory port seen by mem_arbiter.
// slave = arbiter side, master = the core/memory environment driving it.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  // Handshake: a requester holds Req (with stable address/data) until it sees Gnt
  // in the same cycle; a cycle with Req and Gnt both high is the transfer. Dropping
  // Req before Gnt withdraws the request. Rvalid marks read data exactly one cycle
  // after the granting cycle; writes have no response.
  logic                  i_If_Req;
  logic [ADDR_WIDTH-1:0] i_If_Addr;
  logic                  o_If_Gnt;
  logic                  o_If_Rvalid;
  logic [DATA_WIDTH-1:0] o_If_Rdata;

  logic                  i_Ls_Req;
  logic                  i_Ls_Wen;
  logic [BE_WIDTH-1:0]   i_Ls_Be;
  logic [ADDR_WIDTH-1:0] i_Ls_Addr;
  logic [DATA_WIDTH-1:0] i_Ls_Wdata;
  logic                  o_Ls_Gnt;
  logic                  o_Ls_Rvalid;
  logic [DATA_WIDTH-1:0] o_Ls_Rdata;

  logic                  o_Mem_Ren;
  logic [BE_WIDTH-1:0]   o_Mem_Wen;
  logic [ADDR_WIDTH-1:0] o_Mem_Addr;
  logic [DATA_WIDTH-1:0] o_Mem_Wdata;
  logic [DATA_WIDTH-1:0] i_Mem_Rdata;

  modport slave (
    input  i_If_Req, i_If_Addr,
    output o_If_Gnt, o_If_Rvalid, o_If_Rdata,
    input  i_Ls_Req, i_Ls_Wen, i_Ls_Be, i_Ls_Addr, i_Ls_Wdata,
    output o_Ls_Gnt, o_Ls_Rvalid, o_Ls_Rdata,
    output o_Mem_Ren, o_Mem_Wen, o_Mem_Addr, o_Mem_Wdata,
    input  i_Mem_Rdata
  );

  modport master (
    output i_If_Req, i_If_Addr,
    input  o_If_Gnt, o_If_Rvalid, o_If_Rdata,
    output i_Ls_Req, i_Ls_Wen, i_Ls_Be, i_Ls_Addr, i_Ls_Wdata,
    input  o_Ls_Gnt, o_Ls_Rvalid, o_Ls_Rdata,
    input  o_Mem_Ren, o_Mem_Wen, o_Mem_Addr, o_Mem_Wdata,
    output i_Mem_Rdata
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Counts consecutive cycles the IF port is held off; starve_o asserts once the
// count reaches MAX_WAIT so the arbiter lets IF win the next conflict.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic if_req_i,
  input  logic if_gnt_i,
  output logic starve_o
);

  localparam int unsigned    CW      = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!if_req_i || if_gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (LS).
// LS has priority; define ARB_STARVE_GUARD_EN to bound how long IF can be held off.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus,
  output rsp_tag_e      o_Dbg_Rsp_Tag
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("mem_arbiter: DATA_WIDTH must be a multiple of 8");
  end
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mem_arbiter: MAX_WAIT must be at least 1");
  end

  logic                  if_gnt;
  logic                  ls_gnt;
  logic                  starve;
  rsp_tag_e              tag_q;
  rsp_tag_e              tag_d;

  logic                  mem_ren;
  logic [BE_WIDTH-1:0]   mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .if_req_i (bus.i_If_Req),
    .if_gnt_i (if_gnt),
    .starve_o (starve)
  );
`else
  assign starve = 1'b0;
`endif

  // Grant and response-tag next state. The tag is the arbiter's only state:
  // it remembers who owns the read data returning next cycle.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    tag_d  = RSP_NONE;
    if (!i_rst) begin
      if (bus.i_Ls_Req && !(bus.i_If_Req && starve)) begin
        ls_gnt = 1'b1;
      end else if (bus.i_If_Req) begin
        if_gnt = 1'b1;
      end
    end
    if (ls_gnt && !bus.i_Ls_Wen) begin
      tag_d = RSP_LS;
    end else if (if_gnt) begin
      tag_d = RSP_IF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_q <= RSP_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Memory port mux; address and write data stay at zero when nothing is granted.
  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_addr = bus.i_Ls_Addr;
      if (bus.i_Ls_Wen) begin
        mem_wen   = bus.i_Ls_Be;
        mem_wdata = bus.i_Ls_Wdata;
      end else begin
        mem_ren = 1'b1;
      end
    end else if (if_gnt) begin
      mem_addr = bus.i_If_Addr;
      mem_ren  = 1'b1;
    end
  end

  assign bus.o_If_Gnt    = if_gnt;
  assign bus.o_Ls_Gnt    = ls_gnt;
  assign bus.o_Mem_Ren   = mem_ren;
  assign bus.o_Mem_Wen   = mem_wen;
  assign bus.o_Mem_Addr  = mem_addr;
  assign bus.o_Mem_Wdata = mem_wdata;

  // A read granted just before reset must not surface while reset is held.
  assign bus.o_If_Rvalid = !i_rst && (tag_q == RSP_IF);
  assign bus.o_Ls_Rvalid = !i_rst && (tag_q == RSP_LS);
  assign bus.o_If_Rdata  = bus.i_Mem_Rdata;
  assign bus.o_Ls_Rdata  = bus.i_Mem_Rdata;

  assign o_Dbg_Rsp_Tag = tag_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the core's instruction-fetch (IF) port and load/store (LS) port. It sits between the DATAPATH and the memory, granting at most one access per cycle and routing the one-cycle-latency read data back to the port that issued the read. LS has priority; an optional starvation guard bounds how long IF can be held off.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width on all ports
- DATA_WIDTH, 32, data width; must be a multiple of 8
- MAX_WAIT, 4, consecutive denied IF cycles before IF is forced to win; minimum 1

Ports (clock and reset first):
- i_clk  in  1  single clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_If_Req  in  1  IF read request; held high until granted
- i_If_Addr  in  ADDR_WIDTH  IF read address
- o_If_Gnt  out  1  IF request accepted this cycle
- o_If_Rvalid  out  1  IF read data valid
- o_If_Rdata  out  DATA_WIDTH  IF read data
- i_Ls_Req  in  1  LS request; held high until granted
- i_Ls_Wen  in  1  1 = write, 0 = read
- i_Ls_Be  in  DATA_WIDTH/8  write byte enables
- i_Ls_Addr  in  ADDR_WIDTH  LS address
- i_Ls_Wdata  in  DATA_WIDTH  LS write data
- o_Ls_Gnt  out  1  LS request accepted this cycle
- o_Ls_Rvalid  out  1  LS read data valid
- o_Ls_Rdata  out  DATA_WIDTH  LS read data
- o_Mem_Ren  out  1  memory read strobe
- o_Mem_Wen  out  DATA_WIDTH/8  memory byte write strobes
- o_Mem_Addr  out  ADDR_WIDTH  memory address
- o_Mem_Wdata  out  DATA_WIDTH  memory write data
- i_Mem_Rdata  in  DATA_WIDTH  memory read data, valid the cycle after o_Mem_Ren

## Operation
- Grant decision combinational each cycle from requests and starvation state.
- Only LS requesting -> LS granted; only IF -> IF granted; neither -> no grant, memory strobes 0.
- Both requesting -> LS granted, unless starvation flag set (counter == MAX_WAIT) -> IF granted.
- Granted port's address/data/strobes drive memory port; o_Mem_Ren = granted read; o_Mem_Wen = i_Ls_Be on LS write grant, else 0.
- Response tag register, states RSP_NONE / RSP_IF / RSP_LS: loaded each cycle with owner of a granted read, RSP_NONE for write or no grant.
- Tag RSP_IF -> o_If_Rvalid = 1; RSP_LS -> o_Ls_Rvalid = 1. Both Rdata outputs pass i_Mem_Rdata through unconditionally; only Rvalid qualifies.
- Starvation counter: increments when i_If_Req high and not granted, saturates at MAX_WAIT; clears on IF grant or i_If_Req low.
- Requests dropped before grant: legal, no side effect.
- While i_rst high: all Gnt, Rvalid, memory strobes forced 0.

## Timing
- Grant latency: 0 cycles (same cycle as request).
- Read data latency: Rvalid exactly 1 cycle after the granting cycle.
- Throughput: one access per cycle; back-to-back grants to either port allowed, including alternating IF/LS.
- Write completes in grant cycle; no response.
- Worst-case IF wait with guard: MAX_WAIT denied cycles, granted on cycle MAX_WAIT+1.
- Reset values: tag RSP_NONE, counter 0, all outputs 0 (Rdata follows i_Mem_Rdata).
- Reset mid-operation: read granted in the cycle before reset produces no Rvalid; first grant possible in the first cycle with i_rst low.

## Configuration
- ARB_STARVE_GUARD_EN defined: starvation counter and IF forced-win behaviour as above.
- Undefined: strict LS priority; counter absent; MAX_WAIT ignored; IF may starve indefinitely.

## Structure
- Shared package mem_arb_pkg: response-tag enum (RSP_NONE, RSP_IF, RSP_LS) and default parameter constants.
- One sub-module: arb_starve_cnt (saturating counter + flag), instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- IF-only read 0x0000_0010, memory returns 0xDEAD_BEEF -> o_If_Gnt same cycle, o_If_Rvalid next cycle with 0xDEAD_BEEF, o_Ls_Rvalid 0.
- LS write 0x0000_0100, data 0x1234_5678, Be 4'b0011 while IF idle -> o_Mem_Wen 4'b0011 in grant cycle, no Rvalid.
- Both request same cycle, guard off counter -> LS granted, IF granted next cycle after LS drops; Rvalids on consecutive cycles to correct ports.
- LS held continuously, IF requesting, MAX_WAIT=4, guard on -> IF denied 4 cycles, granted 5th; without macro IF never granted.
- Read granted, i_rst asserted next cycle -> no Rvalid; after release, first request granted in first non-reset cycle.
- Alternating IF/LS reads every cycle for 16 cycles -> one grant per cycle, every Rvalid tagged to issuing port with matching data.
